// File: rtl/stepper_move_ctrl_pkg.sv
// Shared definitions for the stepper move controller.
//   - state_e     : sequencer states
//   - DIR_UP/DN   : cmd_dir / motor_dir encodings
//   - FLT_*       : bit positions inside the fault status
//   - MIN_PERIOD  : smallest step period the controller will run
//   - max3        : helper used to size the shared delay timer
package stepper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int unsigned FLT_ABORT = 0;
  localparam int unsigned FLT_LIMIT = 1;

  localparam int unsigned MIN_PERIOD = 2;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/stepper_move_ctrl_if.sv
// Move-command handshake between control logic (master) and the
// stepper move controller (slave).
//   cmd_valid  : command present
//   cmd_ready  : controller can accept a command
//   cmd_dir    : 0 = count up, 1 = count down
//   cmd_steps  : number of steps (unsigned)
//   cmd_period : clk cycles per step
interface stepper_move_ctrl_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PER_W = 20
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [PER_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/stepper_move_ctrl_step_rate_timer.sv
// Loadable period counter. load_i captures len_i and restarts the count
// at 0; while en_i is high the count advances and tick_o is high for the
// cycle in which the count equals len-1, after which it returns to 0.
//   clk, rst : clock, synchronous active-low reset
//   load_i   : capture len_i, restart count
//   len_i    : period length in cycles (>= 1)
//   clr_i    : restart count without changing the length
//   en_i     : count enable
//   tick_o   : one-cycle tick at count len-1
module step_rate_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] len_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic         tick_o
);

  logic [W-1:0] len_q, len_d;
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == (len_q - W'(1)));
  end

  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    if (load_i) begin
      len_d = len_i;
      cnt_d = '0;
    end else if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Stepper motion sequencer. Accepts move commands over a valid/ready
// handshake, then runs IDLE -> SETTLE -> RUN -> HOLD -> DONE, producing
// step pulses at the commanded rate and tracking signed absolute position.
//   clk, rst   : clock, synchronous active-low reset
//   cmd        : command handshake (slave side)
//   abort      : stop motion (SETTLE/RUN only)
//   lim_up/dn  : end-of-travel switches for dir 0 / dir 1
//   motor_en   : phase driver enable
//   motor_dir  : latched direction
//   step_pulse : one-cycle advance pulse
//   position   : signed absolute position (wraps)
//   busy       : not idle
//   done       : one-cycle end-of-command pulse
//   fault      : [0] aborted, [1] limit hit; cleared on accept
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int unsigned POS_W      = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PER_W      = 20,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned HOLD_CYC   = 5000
) (
  input  logic               clk,
  input  logic               rst,
  stepper_move_ctrl_if.slave cmd,
  input  logic               abort,
  input  logic               lim_up,
  input  logic               lim_dn,
  output logic               motor_en,
  output logic               motor_dir,
  output logic               step_pulse,
  output logic [POS_W-1:0]   position,
  output logic               busy,
  output logic               done,
  output logic [1:0]         fault
);

  // One timer serves the settle delay, the step period and the dwell.
  localparam int unsigned TMR_W =
    max3(PER_W, $clog2(SETTLE_CYC + 1), $clog2(HOLD_CYC + 1));

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       flt_q, flt_d;
  logic             step_q, step_d;
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             hs;
  logic             lim_cmd;
  logic             lim_mv;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_len;
  logic             tmr_en;
  logic             tmr_clr;
  logic             tmr_tick;

  step_rate_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .len_i  (tmr_len),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tick_o (tmr_tick)
  );

  // State register (plus latched command and registered outputs)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      rem_q   <= '0;
      per_q   <= '0;
      pos_q   <= '0;
      flt_q   <= '0;
      step_q  <= 1'b0;
      ready_q <= 1'b1;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      pos_q   <= pos_d;
      flt_q   <= flt_d;
      step_q  <= step_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    per_d    = per_q;
    pos_d    = pos_q;
    flt_d    = flt_q;
    step_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_len  = '0;

    hs      = cmd.cmd_valid && ready_q;
    lim_cmd = (cmd.cmd_dir == DIR_DN) ? lim_dn : lim_up;
    lim_mv  = (dir_q == DIR_DN) ? lim_dn : lim_up;
    tmr_en  = (state_q == ST_SETTLE) || (state_q == ST_RUN) ||
              (state_q == ST_HOLD);
    tmr_clr = !tmr_en;

    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          dir_d = cmd.cmd_dir;
          rem_d = cmd.cmd_steps;
          per_d = (cmd.cmd_period < PER_W'(MIN_PERIOD)) ?
                  PER_W'(MIN_PERIOD) : cmd.cmd_period;
          flt_d = '0;
          if (cmd.cmd_steps == '0) begin
            state_d = ST_DONE;
          end else if (lim_cmd) begin
            flt_d[FLT_LIMIT] = 1'b1;
            state_d          = ST_DONE;
          end else begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
            tmr_len  = TMR_W'(SETTLE_CYC);
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          flt_d[FLT_ABORT] = 1'b1;
          state_d          = ST_HOLD;
          tmr_load         = 1'b1;
          tmr_len          = TMR_W'(HOLD_CYC);
        end else if (tmr_tick) begin
          state_d  = ST_RUN;
          tmr_load = 1'b1;
          tmr_len  = TMR_W'(per_q);
        end
      end
      ST_RUN: begin
        // The final pulse is registered, so the move is seen as complete
        // one cycle after the last tick; a stop request that cycle is moot.
        if (rem_q == '0) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_len  = TMR_W'(HOLD_CYC);
        end else if (abort || lim_mv) begin
          // A stop request wins over a coincident step point.
          if (abort)  flt_d[FLT_ABORT] = 1'b1;
          if (lim_mv) flt_d[FLT_LIMIT] = 1'b1;
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_len  = TMR_W'(HOLD_CYC);
        end else if (tmr_tick) begin
          step_d = 1'b1;
          rem_d  = rem_q - CNT_W'(1);
          pos_d  = (dir_q == DIR_DN) ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
        end
      end
      ST_HOLD: begin
        if (tmr_tick) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs, registered from the next state
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    en_d    = (state_d == ST_SETTLE) || (state_d == ST_RUN) ||
              (state_d == ST_HOLD);
  end

  assign cmd.cmd_ready = ready_q;
  assign motor_en      = en_q;
  assign motor_dir     = dir_q;
  assign step_pulse    = step_q;
  assign position      = pos_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = flt_q;

endmodule
